// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bundle and response-buffer state for the shared ALU arbiter.
package alu_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ROL  = 4'd0,
    OP_ROR  = 4'd1,
    OP_MAX  = 4'd2,
    OP_MIN  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SGT  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SRA  = 4'd7,
    OP_NOR  = 4'd8,
    OP_SLL  = 4'd9,
    OP_XNOR = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return op <= OPC_W'(OP_XNOR);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two-requester operation bus plus single response channel of the shared ALU.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 5
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPC_W-1:0] req0_opcode;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SHW-1:0]   req0_shamt;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPC_W-1:0] req1_opcode;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SHW-1:0]   req1_shamt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_illegal;
  logic [15:0]      op_count;

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, req0_shamt,
    output req1_valid, req1_opcode, req1_a, req1_b, req1_shamt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_illegal,
    input  op_count
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, req0_shamt,
    input  req1_valid, req1_opcode, req1_a, req1_b, req1_shamt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_illegal,
    output op_count
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: rotates, shifts, compares, add and bitwise ops with flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 5
) (
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  output logic [WIDTH-1:0] o_result,
  output alu_flags_t       o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [31:0]      w_rot;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_sgt;
  logic             w_slt;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Rotate amount reduced modulo WIDTH; a shift by WIDTH yields 0, so amount 0 returns a.
  assign w_rot = 32'(i_shamt) % WIDTH;
  assign w_rol = (i_a << w_rot) | (i_a >> (WIDTH - w_rot));
  assign w_ror = (i_a >> w_rot) | (i_a << (WIDTH - w_rot));

  assign w_sgt = $signed(i_a) > $signed(i_b);
  assign w_slt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = '0;
    o_flags  = '0;
    case (alu_op_e'(i_opcode))
      OP_ROL:  o_result = w_rol;
      OP_ROR:  o_result = w_ror;
      OP_MAX:  o_result = (i_a > i_b) ? i_a : i_b;
      OP_MIN:  o_result = (i_a < i_b) ? i_a : i_b;
      OP_ADD: begin
        o_result         = w_sum[WIDTH-1:0];
        o_flags.carry    = w_sum[WIDTH];
        o_flags.overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SGT:  o_result = WIDTH'(w_sgt);
      OP_SLT:  o_result = WIDTH'(w_slt);
      OP_SRA:  o_result = $signed(i_a) >>> i_shamt;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SLL:  o_result = i_a << i_shamt;
      OP_XNOR: o_result = ~(i_a ^ i_b);
      default: o_flags.illegal = 1'b1;
    endcase
    if (is_legal(i_opcode)) begin
      o_flags.zero = (o_result == '0);
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters through a single-entry response register.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 5
) (
  input logic              clk,
  input logic              rst_n,
  alu_share_arbiter_if.slave bus
);

  rsp_state_e       r_state;
  rsp_state_e       w_next_state;
  logic             r_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;
  logic [15:0]      r_count;

  logic             w_acc;
  logic             w_grant_any;
  logic             w_grant_id;
  logic             w_take;

  logic [OPC_W-1:0] w_opcode;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_core_result;
  alu_flags_t       w_core_flags;

  // Grant selection and response-buffer next state; nothing is accepted while in reset.
  always_comb begin
    w_next_state = r_state;
    w_acc        = 1'b0;
    w_grant_any  = 1'b0;
    w_grant_id   = r_ptr;
    w_take       = 1'b0;

    w_acc = (r_state == ST_EMPTY) || bus.rsp_ready;

    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_any = 1'b1;
      w_grant_id  = r_ptr;
    end else if (bus.req0_valid) begin
      w_grant_any = 1'b1;
      w_grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      w_grant_any = 1'b1;
      w_grant_id  = 1'b1;
    end

    w_take = rst_n && w_acc && w_grant_any;

    case (r_state)
      ST_EMPTY: if (w_take) w_next_state = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !w_take) w_next_state = ST_EMPTY;
      default:  w_next_state = ST_EMPTY;
    endcase
  end

  assign bus.req0_ready = w_take && !w_grant_id;
  assign bus.req1_ready = w_take && w_grant_id;

  assign w_opcode = w_grant_id ? bus.req1_opcode : bus.req0_opcode;
  assign w_a      = w_grant_id ? bus.req1_a      : bus.req0_a;
  assign w_b      = w_grant_id ? bus.req1_b      : bus.req0_b;
  assign w_shamt  = w_grant_id ? bus.req1_shamt  : bus.req0_shamt;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .i_opcode (w_opcode),
    .i_a      (w_a),
    .i_b      (w_b),
    .i_shamt  (w_shamt),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Response payload, priority pointer and consumed-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= 1'b0;
      r_id     <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_count  <= '0;
    end else begin
      if (w_take) begin
        r_id     <= w_grant_id;
        r_result <= w_core_result;
        r_flags  <= w_core_flags;
        r_ptr    <= !w_grant_id;
      end
      if ((r_state == ST_FULL) && bus.rsp_ready) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.rsp_valid    = (r_state == ST_FULL);
  assign bus.rsp_id       = r_id;
  assign bus.rsp_result   = r_result;
  assign bus.rsp_carry    = r_flags.carry;
  assign bus.rsp_zero     = r_flags.zero;
  assign bus.rsp_overflow = r_flags.overflow;
  assign bus.rsp_illegal  = r_flags.illegal;
  assign bus.op_count     = r_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a behavioural reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned SW = 5;

  typedef struct {
    logic           v;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SW-1:0]  sh;
  } req_t;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_share_arbiter_if #(.WIDTH(W), .SHW(SW)) bus ();

  alu_share_arbiter #(.WIDTH(W), .SHW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        m_valid;
  logic        m_ptr;
  logic        m_id;
  logic [15:0] m_count;
  exp_t        m_rsp;
  int          last_g;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SW-1:0] sh);
    exp_t            e;
    logic [W:0]      s;
    logic signed [W:0] ss;
    int              n;
    e.res = '0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0;
    n = int'(sh);
    case (op)
      4'd0: for (int i = 0; i < int'(W); i++) e.res[(i + n) % int'(W)] = a[i];
      4'd1: for (int i = 0; i < int'(W); i++) e.res[i] = a[(i + n) % int'(W)];
      4'd2: e.res = (a > b) ? a : b;
      4'd3: e.res = (a < b) ? a : b;
      4'd4: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c   = s[W];
        ss    = $signed({a[W-1], a}) + $signed({b[W-1], b});
        e.o   = ss[W] != ss[W-1];
      end
      4'd5: e.res = ($signed(a) > $signed(b)) ? 64'd1 : 64'd0;
      4'd6: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd7: for (int i = 0; i < int'(W); i++) e.res[i] = (i + n < int'(W)) ? a[i + n] : a[W-1];
      4'd8: e.res = ~(a | b);
      4'd9: for (int i = 0; i < int'(W); i++) e.res[i] = (i >= n) ? a[i - n] : 1'b0;
      4'd10: e.res = ~(a ^ b);
      default: e.ill = 1'b1;
    endcase
    e.z = !e.ill && (e.res == '0);
    return e;
  endfunction

  function automatic req_t mk(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [SW-1:0] sh);
    req_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.sh = sh;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_val();
    logic [W-1:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: x = '0;
      1: x = '1;
      2: x = {1'b1, 63'd0};
      3: x = {1'b0, {63{1'b1}}};
      default: ;
    endcase
    return x;
  endfunction

  function automatic req_t rand_req();
    return mk(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), rand_val(), rand_val(),
              SW'($urandom_range(0, 31)));
  endfunction

  task automatic drive(input req_t r0, input req_t r1, input logic rr);
    bus.req0_valid = r0.v; bus.req0_opcode = r0.op; bus.req0_a = r0.a;
    bus.req0_b = r0.b; bus.req0_shamt = r0.sh;
    bus.req1_valid = r1.v; bus.req1_opcode = r1.op; bus.req1_a = r1.a;
    bus.req1_b = r1.b; bus.req1_shamt = r1.sh;
    bus.rsp_ready = rr;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ptr = 1'b0; m_id = 1'b0; m_count = '0; last_g = -1;
    m_rsp.res = '0; m_rsp.c = 1'b0; m_rsp.z = 1'b0; m_rsp.o = 1'b0; m_rsp.ill = 1'b0;
  endtask

  task automatic check_rsp();
    chk("rsp_valid", W'(bus.rsp_valid), W'(m_valid));
    chk("op_count", W'(bus.op_count), W'(m_count));
    if (m_valid) begin
      chk("rsp_id", W'(bus.rsp_id), W'(m_id));
      chk("rsp_result", bus.rsp_result, m_rsp.res);
      chk("rsp_carry", W'(bus.rsp_carry), W'(m_rsp.c));
      chk("rsp_zero", W'(bus.rsp_zero), W'(m_rsp.z));
      chk("rsp_overflow", W'(bus.rsp_overflow), W'(m_rsp.o));
      chk("rsp_illegal", W'(bus.rsp_illegal), W'(m_rsp.ill));
    end
  endtask

  // One clock: check held response, present requests, check readies, then advance the model.
  task automatic cycle(input req_t r0, input req_t r1, input logic rr);
    logic acc, any, g;
    exp_t e;
    @(negedge clk);
    check_rsp();
    drive(r0, r1, rr);
    #1;
    acc = !m_valid || rr;
    any = r0.v || r1.v;
    g   = (r0.v && r1.v) ? m_ptr : r1.v;
    chk("req0_ready", W'(bus.req0_ready), W'(acc && any && !g));
    chk("req1_ready", W'(bus.req1_ready), W'(acc && any && g));
    @(posedge clk);
    #1;
    if (m_valid && rr) m_count = m_count + 16'd1;
    if (acc && any) begin
      e = g ? ref_alu(r1.op, r1.a, r1.b, r1.sh) : ref_alu(r0.op, r0.a, r0.b, r0.sh);
      m_rsp   = e;
      m_id    = g;
      m_ptr   = !g;
      m_valid = 1'b1;
      last_g  = int'(g);
    end else begin
      last_g = -1;
      if (rr) m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    req_t busy;
    busy = mk(1'b1, 4'd4, 64'd1, 64'd1, 5'd0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(busy, busy, 1'b1);
    #1;
    chk("rst_rsp_valid", W'(bus.rsp_valid), 64'd0);
    chk("rst_op_count", W'(bus.op_count), 64'd0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_flags", W'({bus.rsp_carry, bus.rsp_zero, bus.rsp_overflow, bus.rsp_illegal}), 64'd0);
    chk("rst_rsp_id", W'(bus.rsp_id), 64'd0);
    chk("rst_ready0", W'(bus.req0_ready), 64'd0);
    chk("rst_ready1", W'(bus.req1_ready), 64'd0);
    model_reset();
    @(negedge clk);
    drive(mk(1'b0, 4'd0, '0, '0, '0), mk(1'b0, 4'd0, '0, '0, '0), 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    req_t idle;
    int   grants [4];
    idle  = mk(1'b0, 4'd0, '0, '0, '0);
    rst_n = 1'b0;
    drive(idle, idle, 1'b0);
    model_reset();
    do_reset();

    // Both requesters valid every cycle: strict alternation from requester 0.
    for (int k = 0; k < 4; k++) begin
      cycle(mk(1'b1, 4'd4, 64'(k), 64'd10, 5'd0), mk(1'b1, 4'd3, 64'(k), 64'd7, 5'd0), 1'b1);
      grants[k] = last_g;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), W'(grants[k]), W'(k % 2));
    cycle(idle, idle, 1'b1);
    chk("op_count_four", W'(bus.op_count), 64'd4);

    cycle(mk(1'b1, 4'd4, '1, 64'd1, 5'd0), idle, 1'b1);
    chk("add_wrap_result", bus.rsp_result, 64'd0);
    chk("add_wrap_carry", W'(bus.rsp_carry), 64'd1);
    chk("add_wrap_zero", W'(bus.rsp_zero), 64'd1);
    chk("add_wrap_ovf", W'(bus.rsp_overflow), 64'd0);
    chk("add_wrap_id", W'(bus.rsp_id), 64'd0);

    cycle(mk(1'b1, 4'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd0), idle, 1'b1);
    chk("add_ovf_result", bus.rsp_result, 64'h8000_0000_0000_0000);
    chk("add_ovf_ovf", W'(bus.rsp_overflow), 64'd1);
    chk("add_ovf_carry", W'(bus.rsp_carry), 64'd0);
    cycle(idle, mk(1'b1, 4'd6, '1, 64'd0, 5'd0), 1'b1);
    chk("slt_result", bus.rsp_result, 64'd1);
    chk("slt_id", W'(bus.rsp_id), 64'd1);

    cycle(mk(1'b1, 4'd13, 64'd5, 64'd5, 5'd3), idle, 1'b1);
    chk("illegal_result", bus.rsp_result, 64'd0);
    chk("illegal_flag", W'(bus.rsp_illegal), 64'd1);
    chk("illegal_zero", W'(bus.rsp_zero), 64'd0);
    cycle(mk(1'b1, 4'd0, 64'h8000_0000_0000_0001, 64'd0, 5'd1), idle, 1'b1);
    chk("rol_result", bus.rsp_result, 64'd3);

    // Consumer stalls with the buffer full; requester 1 waits, then goes in on release.
    for (int k = 0; k < 3; k++) begin
      cycle(idle, mk(1'b1, 4'd2, 64'd5, 64'd9, 5'd0), 1'b0);
      chk($sformatf("stall_hold%0d", k), bus.rsp_result, 64'd3);
      chk($sformatf("stall_valid%0d", k), W'(bus.rsp_valid), 64'd1);
    end
    cycle(idle, mk(1'b1, 4'd2, 64'd5, 64'd9, 5'd0), 1'b1);
    chk("release_id", W'(bus.rsp_id), 64'd1);
    chk("release_result", bus.rsp_result, 64'd9);

    // Reset while full, then first contended grant goes to requester 0.
    do_reset();
    cycle(mk(1'b1, 4'd5, 64'd2, 64'd1, 5'd0), mk(1'b1, 4'd5, 64'd1, 64'd2, 5'd0), 1'b1);
    chk("post_rst_id", W'(bus.rsp_id), 64'd0);
    chk("post_rst_result", bus.rsp_result, 64'd1);

    for (int k = 0; k < 400; k++) begin
      cycle(rand_req(), rand_req(), ($urandom_range(0, 3) != 0));
    end
    cycle(idle, idle, 1'b1);
    cycle(idle, idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width.
REQ-002 Parameter SHW, default 5: shift-amount width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  operation of requester N accepted this cycle.
REQ-007 reqN_opcode  input  4  operation select, encoded per REQ-015.
REQ-008 reqN_a, reqN_b  input  WIDTH  operands.
REQ-009 reqN_shamt  input  SHW  shift/rotate amount.
REQ-010 rsp_valid  output  1  response register holds a result.
REQ-011 rsp_ready  input  1  consumer takes the response this cycle.
REQ-012 rsp_id  output  1  requester index owning the response.
REQ-013 rsp_result  output  WIDTH; rsp_carry, rsp_zero, rsp_overflow, rsp_illegal  output  1 each.
REQ-014 op_count  output  16  count of responses consumed.

Function
REQ-015 Opcodes: 0 ROL, 1 ROR, 2 MAX, 3 MIN, 4 ADD, 5 SGT, 6 SLT, 7 SRA, 8 NOR, 9 SLL, 10 XNOR; 11-15 illegal.
REQ-016 ROL/ROR: rotate a by shamt; shamt=0 returns a unchanged.
REQ-017 SRA: arithmetic right shift of a by shamt. SLL: logical left shift of a by shamt.
REQ-018 MAX/MIN: unsigned compare of a and b. SGT/SLT: signed compare; result is 1 if true, else 0, zero-extended.
REQ-019 ADD: WIDTH-bit sum. Carry = bit WIDTH of the unsigned sum. Overflow = operands have equal MSBs and the sum MSB differs.
REQ-020 Carry and overflow are 0 for every opcode other than ADD.
REQ-021 Zero = (result == 0) for all legal opcodes.
REQ-022 Illegal opcode: result 0, carry 0, overflow 0, zero 0, rsp_illegal 1. rsp_illegal is 0 for legal opcodes.
REQ-023 The response buffer has two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-024 Accept enable acc = !rsp_valid || rsp_ready. The accept path is a full-throughput, single-entry pipeline.
REQ-025 Grant when acc=1:
- Only one reqN_valid is high: grant that requester.
- Both are high: grant the requester named by priority pointer ptr.
- Neither is high: no grant.
REQ-026 reqN_ready = acc && grant to N. At most one ready is high per cycle. Ready never depends on rsp_ready of a later cycle.
REQ-027 After a grant to N, ptr becomes !N. With no grant, ptr holds.
REQ-028 Latency: an operation accepted at edge k appears on the rsp_* outputs after edge k, with rsp_valid=1, one cycle total.
REQ-029 State transitions:
- EMPTY, grant: go to FULL.
- FULL, rsp_ready with grant: stay FULL, new result loaded.
- FULL, rsp_ready without grant: go to EMPTY.
- FULL, !rsp_ready: hold all rsp_* stable.
REQ-030 op_count increments on each rsp_valid && rsp_ready and wraps 0xFFFF to 0x0000.
REQ-031 reqN_* inputs are sampled only at the accepting edge. Input changes while reqN_ready=0 have no effect.

Reset
REQ-032 Asserting rst_n low immediately clears: rsp_valid, rsp_id, rsp_result, all flags, op_count; sets ptr to 0.
REQ-033 Reset mid-operation discards any held response without handshake. reqN_ready is 0 while rst_n is low.
REQ-034 The first grant after reset release, with both requesters valid, goes to requester 0.

Structure
REQ-035 Shared package alu_pkg holds:
- the opcode localparams/enum (REQ-015);
- the flag bundle typedef (carry, zero, overflow, illegal).
REQ-036 Sub-module alu_core: purely combinational, implements REQ-015 to REQ-022. It is instantiated once; the arbiter registers its outputs.

Verification
REQ-037 Req0 only, ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, rsp_ready=1 -> next cycle: result 0, carry 1, zero 1, overflow 0, rsp_id 0.
REQ-038 Both valid on every cycle, rsp_ready=1, after reset -> grants alternate 0,1,0,1. op_count reaches 4 after four responses.
REQ-039 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x8000_0000_0000_0000, overflow 1, carry 0. SLT a=-1, b=0 -> result 1.
REQ-040 Response FULL, rsp_ready=0 for 3 cycles, req1 valid -> rsp_* stable and req1_ready=0. Then rsp_ready=1 -> req1 accepted in the same cycle.
REQ-041 Opcode 13 -> result 0, rsp_illegal 1, zero 0. ROL a=0x8000_0000_0000_0001, shamt=1 -> result 0x3.
REQ-042 rst_n low while FULL -> rsp_valid 0 immediately. op_count 0. After release, ptr 0.
